// File: rtl/pdm_capture.sv
// PDM microphone front end: generates the PDM clock, samples the bitstream
// once per period and converts each WINDOW-bit block to a signed PCM sample.
module pdm_capture #(
    parameter int unsigned CLK_HALF = 25,
    parameter int unsigned WINDOW   = 128
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        enable_i,
    output logic        done_o,
    output logic [15:0] data_o,
    output logic        pdm_clk_o,
    input  logic        pdm_data_i,
    output logic        pdm_lrsel_o
);

    localparam int unsigned DivW  = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam int unsigned CntW  = $clog2(WINDOW);
    localparam int unsigned OnesW = $clog2(WINDOW + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [DivW-1:0]    div_q, div_d;
    logic [CntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [OnesW-1:0]   ones_q, ones_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               pdm_clk_q, pdm_clk_d;
    logic               done_q, done_d;
    logic [15:0]        data_q, data_d;

    logic               sample;
    logic [OnesW-1:0]   ones_inc;
    logic [15:0]        pcm;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        pdm_clk_d = pdm_clk_q;
        data_d    = data_q;
        done_d    = 1'b0;
        sync1_d   = pdm_data_i;
        sync2_d   = sync1_q;
        sample    = 1'b0;
        ones_inc  = ones_q + OnesW'(sync2_q);
        // 2*ones - WINDOW, truncated to 16 bits gives the two's-complement sample
        pcm       = 16'(32'(ones_inc) * 32'd2 - 32'(WINDOW));

        unique case (state_q)
            StIdle: begin
                pdm_clk_d = 1'b0;
                div_d     = '0;
                bit_cnt_d = '0;
                ones_d    = '0;
                if (enable_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (div_q == DivW'(CLK_HALF - 1)) begin
                    div_d     = '0;
                    pdm_clk_d = ~pdm_clk_q;
                    sample    = pdm_clk_q;
                end else begin
                    div_d = div_q + 1'b1;
                end

                if (sample) begin
                    if (bit_cnt_q == CntW'(WINDOW - 1)) begin
                        data_d    = pcm;
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        ones_d    = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        ones_d    = ones_inc;
                    end
                end

                // A completing sample still lands; only partial windows are dropped.
                if (!enable_i) begin
                    state_d   = StIdle;
                    pdm_clk_d = 1'b0;
                    div_d     = '0;
                    bit_cnt_d = '0;
                    ones_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pdm_clk_q <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pdm_clk_q <= pdm_clk_d;
            done_q    <= done_d;
            data_q    <= data_d;
        end
    end

    assign done_o      = done_q;
    assign data_o      = data_q;
    assign pdm_clk_o   = pdm_clk_q;
    assign pdm_lrsel_o = 1'b0;

endmodule

// File: tb/tb_pdm_capture.sv
// Bench for pdm_capture: default and small-parameter instances checked every cycle
// against a time-based reference model, plus directed timing/value checks.
module tb_pdm_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        pdm;

    logic        done_a, clk_a, lrsel_a;
    logic [15:0] data_a;
    logic        done_b, clk_b, lrsel_b;
    logic [15:0] data_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pdm_capture u_dut_a (
        .clock_i    (clk),
        .reset_i    (reset),
        .enable_i   (enable),
        .done_o     (done_a),
        .data_o     (data_a),
        .pdm_clk_o  (clk_a),
        .pdm_data_i (pdm),
        .pdm_lrsel_o(lrsel_a)
    );

    pdm_capture #(
        .CLK_HALF(2),
        .WINDOW  (4)
    ) u_dut_b (
        .clock_i    (clk),
        .reset_i    (reset),
        .enable_i   (enable),
        .done_o     (done_b),
        .data_o     (data_b),
        .pdm_clk_o  (clk_b),
        .pdm_data_i (pdm),
        .pdm_lrsel_o(lrsel_b)
    );

    // Abstract model: t counts cycles since t0; everything else follows from t.
    typedef struct {
        bit          run;
        int          t;
        int          ones;
        logic [15:0] data;
        bit          done;
        bit          s1;
        bit          s2;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_step(mdl_t m, bit rst, bit en, bit pd, int ch, int w);
        mdl_t n;
        int   per;
        n = m;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        per    = 2 * ch;
        n.done = 1'b0;
        n.s1   = pd;
        n.s2   = m.s1;
        if (m.run) begin
            if (m.t % per == per - 1) begin
                n.ones = m.ones + int'(m.s2);
                if ((m.t / per) % w == w - 1) begin
                    n.data = 16'(2 * n.ones - w);
                    n.done = 1'b1;
                    n.ones = 0;
                end
            end
            if (!en) begin
                n.run  = 1'b0;
                n.t    = 0;
                n.ones = 0;
            end else begin
                n.t = m.t + 1;
            end
        end else if (en) begin
            n.run  = 1'b1;
            n.t    = 0;
            n.ones = 0;
        end
        return n;
    endfunction

    function automatic bit mdl_clk(mdl_t m, int ch);
        return m.run && ((m.t / ch) % 2 == 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        ma = mdl_step(ma, reset, enable, pdm, 25, 128);
        mb = mdl_step(mb, reset, enable, pdm, 2, 4);
        @(negedge clk);
        check_eq("a_done", 32'(done_a), 32'(ma.done));
        check_eq("a_data", 32'(data_a), 32'(ma.data));
        check_eq("a_pclk", 32'(clk_a), 32'(mdl_clk(ma, 25)));
        check_eq("a_lrsel", 32'(lrsel_a), 32'd0);
        check_eq("b_done", 32'(done_b), 32'(mb.done));
        check_eq("b_data", 32'(data_b), 32'(mb.data));
        check_eq("b_pclk", 32'(clk_b), 32'(mdl_clk(mb, 2)));
        check_eq("b_lrsel", 32'(lrsel_b), 32'd0);
    endtask

    initial begin
        int   hi_len, lo_len, run_len;
        logic prev;
        int   pat[4];

        pat    = '{1, 1, 1, 0};
        ma     = '{default: 0};
        mb     = '{default: 0};
        reset  = 1'b1;
        enable = 1'b0;
        pdm    = 1'b0;
        repeat (3) tick();
        check_eq("rst_data", 32'(data_a), 32'h0);
        check_eq("rst_done", 32'(done_a), 32'h0);
        check_eq("rst_pclk", 32'(clk_a), 32'h0);

        // All-ones bitstream
        reset = 1'b0;
        pdm   = 1'b1;
        repeat (4) tick();
        enable = 1'b1;
        tick();
        repeat (6399) tick();
        check_eq("ones_early", 32'(done_a), 32'h0);
        tick();
        check_eq("ones_done", 32'(done_a), 32'h1);
        check_eq("ones_data", 32'(data_a), 32'h0080);
        repeat (6399) tick();
        tick();
        check_eq("ones_done2", 32'(done_a), 32'h1);

        // All-zeros bitstream
        enable = 1'b0;
        pdm    = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        tick();
        repeat (6400) tick();
        check_eq("zeros_done", 32'(done_a), 32'h1);
        check_eq("zeros_data", 32'(data_a), 32'hFF80);

        // Alternating bits, toggled on each falling pdm clock edge
        enable = 1'b0;
        repeat (4) tick();
        enable  = 1'b1;
        tick();
        prev    = clk_a;
        run_len = 1;
        hi_len  = 0;
        lo_len  = 0;
        for (int i = 0; i < 6400; i++) begin
            tick();
            if (clk_a != prev) begin
                if (prev) begin
                    hi_len = run_len;
                    pdm    = ~pdm;
                end else begin
                    lo_len = run_len;
                end
                run_len = 0;
            end
            run_len++;
            prev = clk_a;
        end
        check_eq("alt_done", 32'(done_a), 32'h1);
        check_eq("alt_data", 32'(data_a), 32'h0000);
        check_eq("alt_hi_len", 32'(hi_len), 32'd25);
        check_eq("alt_lo_len", 32'(lo_len), 32'd25);

        // Enable dropped mid-window
        enable = 1'b0;
        pdm    = 1'b1;
        repeat (4) tick();
        enable = 1'b1;
        tick();
        repeat (3000) tick();
        enable = 1'b0;
        tick();
        check_eq("drop_pclk", 32'(clk_a), 32'h0);
        repeat (100) tick();
        check_eq("drop_data_kept", 32'(data_a), 32'h0000);
        enable = 1'b1;
        tick();
        repeat (6399) tick();
        check_eq("reen_early", 32'(done_a), 32'h0);
        tick();
        check_eq("reen_done", 32'(done_a), 32'h1);
        check_eq("reen_data", 32'(data_a), 32'h0080);

        // Reset mid-window, then a fresh full window after release
        repeat (4000) tick();
        reset = 1'b1;
        tick();
        check_eq("mrst_data", 32'(data_a), 32'h0);
        check_eq("mrst_pclk", 32'(clk_a), 32'h0);
        reset = 1'b0;
        tick();
        repeat (6400) tick();
        check_eq("mrst_done", 32'(done_a), 32'h1);
        check_eq("mrst_data2", 32'(data_a), 32'h0080);

        // Small instance: bits 1,1,1,0 with enable dropped on the completion cycle
        enable = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        tick();
        for (int j = 0; j < 16; j++) begin
            pdm = pat[j/4][0];
            if (j == 15) enable = 1'b0;
            tick();
        end
        check_eq("small_done", 32'(done_b), 32'h1);
        check_eq("small_data", 32'(data_b), 32'h0002);
        tick();
        check_eq("small_done_off", 32'(done_b), 32'h0);
        check_eq("small_idle_pclk", 32'(clk_b), 32'h0);

        // Randomized traffic
        enable = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            pdm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            reset = ($urandom_range(0, 4999) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
